// File: rtl/piccolo128_dec_if.sv
// piccolo128_dec_if: key/block handshake bundle for the Piccolo-128 decryption core.
// Optional macro PICCOLO128_DEC_ENCMODE_EN adds the per-block `mode` select.
interface piccolo128_dec_if;
    logic         key_load;
    logic [127:0] key_in;
    logic         start;
    logic [63:0]  ct_in;
`ifdef PICCOLO128_DEC_ENCMODE_EN
    logic         mode;
`endif
    logic         key_ready;
    logic         busy;
    logic         done;
    logic [63:0]  pt_out;

`ifdef PICCOLO128_DEC_ENCMODE_EN
    modport master (
        output key_load, key_in, start, ct_in, mode,
        input  key_ready, busy, done, pt_out
    );
    modport slave (
        input  key_load, key_in, start, ct_in, mode,
        output key_ready, busy, done, pt_out
    );
`else
    modport master (
        output key_load, key_in, start, ct_in,
        input  key_ready, busy, done, pt_out
    );
    modport slave (
        input  key_load, key_in, start, ct_in,
        output key_ready, busy, done, pt_out
    );
`endif
endinterface

// File: rtl/piccolo128_dec.sv
// piccolo128_dec: iterative Piccolo-128 decryption, one round per clock.
// Round keys are expanded once per key load into a 31x32 store and replayed
// from the top for every block. Defining PICCOLO128_DEC_ENCMODE_EN adds an
// encrypt direction selected per block by bus.mode.
module piccolo128_dec (
    input logic             clk,
    input logic             reset,
    piccolo128_dec_if.slave bus
);

    localparam int unsigned NR    = 31;
    localparam int unsigned RK_AW = 5;

    typedef enum logic [1:0] {StIdle, StKexp, StDec} state_e;

    // ---------------------------------------------------------------------
    // Cipher primitives
    // ---------------------------------------------------------------------
    function automatic logic [3:0] sbox(input logic [3:0] x);
        logic [3:0] y;
        case (x)
            4'h0: y = 4'he;
            4'h1: y = 4'h4;
            4'h2: y = 4'hb;
            4'h3: y = 4'h2;
            4'h4: y = 4'h3;
            4'h5: y = 4'h8;
            4'h6: y = 4'h0;
            4'h7: y = 4'h9;
            4'h8: y = 4'h1;
            4'h9: y = 4'ha;
            4'ha: y = 4'h7;
            4'hb: y = 4'hf;
            4'hc: y = 4'h6;
            4'hd: y = 4'hc;
            4'he: y = 4'h5;
            default: y = 4'hd;
        endcase
        return y;
    endfunction

    // Multiply by x in GF(2^4) mod x^4+x+1.
    function automatic logic [3:0] mul2(input logic [3:0] x);
        return {x[2:0], 1'b0} ^ {2'b00, x[3], x[3]};
    endfunction

    function automatic logic [3:0] mul3(input logic [3:0] x);
        return mul2(x) ^ x;
    endfunction

    // F: S-layer, diffusion matrix M, S-layer. Nibble 0 is the MSB nibble.
    function automatic logic [15:0] f_fn(input logic [15:0] x);
        logic [3:0] s0, s1, s2, s3;
        logic [3:0] y0, y1, y2, y3;
        s0 = sbox(x[15:12]);
        s1 = sbox(x[11:8]);
        s2 = sbox(x[7:4]);
        s3 = sbox(x[3:0]);
        y0 = mul2(s0) ^ mul3(s1) ^ s2       ^ s3;
        y1 = s0       ^ mul2(s1) ^ mul3(s2) ^ s3;
        y2 = s0       ^ s1       ^ mul2(s2) ^ mul3(s3);
        y3 = mul3(s0) ^ s1       ^ s2       ^ mul2(s3);
        return {sbox(y0), sbox(y1), sbox(y2), sbox(y3)};
    endfunction

    // Round permutation: output bytes (0..7) take input bytes (2,7,4,1,6,3,0,5).
    function automatic logic [63:0] rp_fn(input logic [63:0] x);
        return {x[47:40], x[7:0], x[31:24], x[55:48],
                x[15:8], x[39:32], x[63:56], x[23:16]};
    endfunction

    // Key word k_idx, k0 being the most significant 16 bits.
    function automatic logic [15:0] kword(input logic [127:0] key, input logic [2:0] idx);
        return key[{~idx, 4'b0000} +: 16];
    endfunction

    // (k0..k7) <- (k2,k1,k6,k7,k0,k3,k4,k5)
    function automatic logic [127:0] key_perm(input logic [127:0] k);
        return {k[95:80], k[111:96], k[31:16], k[15:0],
                k[127:112], k[79:64], k[63:48], k[47:32]};
    endfunction

    // {wk0, wk1, wk2, wk3} from the original master key.
    function automatic logic [63:0] whiten_keys(input logic [127:0] k);
        return {k[127:120], k[103:96],   // wk0 = k0L | k1R
                k[111:104], k[119:112],  // wk1 = k1L | k0R
                k[63:56],   k[7:0],      // wk2 = k4L | k7R
                k[15:8],    k[55:48]};   // wk3 = k7L | k4R
    endfunction

    // ---------------------------------------------------------------------
    // State
    // ---------------------------------------------------------------------
    state_e             state_q;
    logic [RK_AW-1:0]   cnt_q;
    logic [127:0]       key_q;
    logic [63:0]        wk_q;
    logic [63:0]        x_q;
    logic [63:0]        pt_q;
    logic               done_q;
    logic               busy_q;
    logic               key_ready_q;
`ifdef PICCOLO128_DEC_ENCMODE_EN
    logic               mode_q;
`endif

    logic [31:0]        rk_mem [NR];

    // ---------------------------------------------------------------------
    // Combinational datapath
    // ---------------------------------------------------------------------
    logic [127:0]       kexp_key;
    logic [31:0]        kexp_pair;
    logic [31:0]        con_word;
    logic [4:0]         con_c;
    logic [RK_AW-1:0]   rd_addr;
    logic               rk_swap;
    logic [31:0]        rk_word;
    logic [15:0]        rk0;
    logic [15:0]        rk1;
    logic [63:0]        round_out;
    logic [63:0]        x_next;
    logic [63:0]        in_mask;
    logic [63:0]        out_mask;

    // Key schedule step: cycle i emits {rk_2i, rk_2i+1}; the word permutation
    // lands on every fourth cycle, just before rk_{8m+6} is taken from k0.
    always_comb begin
        kexp_key  = (cnt_q[1:0] == 2'd3) ? key_perm(key_q) : key_q;
        con_c     = cnt_q + 5'd1;
        con_word  = {con_c, 5'd0, con_c, 2'b00, con_c, 5'd0, con_c} ^ 32'h6547a98b;
        kexp_pair = '0;
        unique case (cnt_q[1:0])
            2'd0: kexp_pair = {kword(kexp_key, 3'd2), kword(kexp_key, 3'd3)};
            2'd1: kexp_pair = {kword(kexp_key, 3'd4), kword(kexp_key, 3'd5)};
            2'd2: kexp_pair = {kword(kexp_key, 3'd6), kword(kexp_key, 3'd7)};
            2'd3: kexp_pair = {kword(kexp_key, 3'd0), kword(kexp_key, 3'd1)};
        endcase
        kexp_pair = kexp_pair ^ con_word;
    end

    // One Feistel round; decryption walks the store backwards and swaps the
    // pair on odd rounds. RP is skipped on the final round.
    always_comb begin
        rd_addr = RK_AW'(NR - 1) - cnt_q;
        rk_swap = cnt_q[0];
`ifdef PICCOLO128_DEC_ENCMODE_EN
        if (mode_q) begin
            rd_addr = cnt_q;
            rk_swap = 1'b0;
        end
`endif
        rk_word   = rk_mem[rd_addr];
        rk0       = rk_swap ? rk_word[15:0]  : rk_word[31:16];
        rk1       = rk_swap ? rk_word[31:16] : rk_word[15:0];
        round_out = {x_q[63:48], x_q[47:32] ^ f_fn(x_q[63:48]) ^ rk0,
                     x_q[31:16], x_q[15:0]  ^ f_fn(x_q[31:16]) ^ rk1};
        x_next    = (cnt_q == RK_AW'(NR - 1)) ? round_out : rp_fn(round_out);
    end

    // Whitening masks on X0/X2: wk2/wk3 in and wk0/wk1 out when decrypting.
    always_comb begin
        in_mask  = {wk_q[31:16], 16'h0000, wk_q[15:0], 16'h0000};
        out_mask = {wk_q[63:48], 16'h0000, wk_q[47:32], 16'h0000};
`ifdef PICCOLO128_DEC_ENCMODE_EN
        if (bus.mode) begin
            in_mask = {wk_q[63:48], 16'h0000, wk_q[47:32], 16'h0000};
        end
        if (mode_q) begin
            out_mask = {wk_q[31:16], 16'h0000, wk_q[15:0], 16'h0000};
        end
`endif
    end

    // Round-key store write port; contents are don't-care until a key load.
    always_ff @(posedge clk) begin
        if (state_q == StKexp) begin
            rk_mem[cnt_q] <= kexp_pair;
        end
    end

    // Control FSM with registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            key_q       <= '0;
            wk_q        <= '0;
            x_q         <= '0;
            pt_q        <= '0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
            key_ready_q <= 1'b0;
`ifdef PICCOLO128_DEC_ENCMODE_EN
            mode_q      <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    // key_load has priority; start needs a complete key set.
                    if (bus.key_load) begin
                        state_q     <= StKexp;
                        key_q       <= bus.key_in;
                        wk_q        <= whiten_keys(bus.key_in);
                        key_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                        cnt_q       <= '0;
                    end else if (bus.start && key_ready_q) begin
                        state_q <= StDec;
                        x_q     <= bus.ct_in ^ in_mask;
                        busy_q  <= 1'b1;
                        cnt_q   <= '0;
`ifdef PICCOLO128_DEC_ENCMODE_EN
                        mode_q  <= bus.mode;
`endif
                    end
                end
                StKexp: begin
                    key_q <= kexp_key;
                    if (cnt_q == RK_AW'(NR - 1)) begin
                        state_q     <= StIdle;
                        busy_q      <= 1'b0;
                        key_ready_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + RK_AW'(1);
                    end
                end
                StDec: begin
                    // Counts 0..30 are rounds; count 31 is the output-whitening cycle.
                    if (cnt_q == RK_AW'(NR)) begin
                        state_q <= StIdle;
                        pt_q    <= x_q ^ out_mask;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                    end else begin
                        x_q   <= x_next;
                        cnt_q <= cnt_q + RK_AW'(1);
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.key_ready = key_ready_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.pt_out    = pt_q;

endmodule

// File: doc/piccolo128_dec.md
Name:
piccolo128_dec

Overview:
- Iterative Piccolo-128 decryption core: 64-bit block, 128-bit key, 31 rounds, one round per clock.
- Counterpart to the team's unrolled Piccolo-128 encryption core. Consumes its ciphertext and returns the original plaintext.
- Round keys are expanded once per key load into an internal 31x32-bit round-key store. They are then replayed in reverse order for each block.

Parameters:
- NR, 31, number of rounds; fixed by Piccolo-128 and not user-tunable.
- RK_AW, 5, round-key store address width (addresses 0..NR-1).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset; clears all state.
- key_load  in  1  one-cycle strobe; captures key_in and starts key expansion.
- key_in  in  128  master key K, bit 0 = MSB; k0..k7 are 16-bit words, k0 = key_in[0:15].
- start  in  1  one-cycle strobe; captures ct_in and starts decryption.
- ct_in  in  64  ciphertext, bit 0 = MSB.
- key_ready  out  1  high when a complete round-key set is stored.
- busy  out  1  high while in KEXP or DEC.
- done  out  1  one-cycle pulse; pt_out is valid in that cycle.
- pt_out  out  64  recovered plaintext; held until the next done.

Behaviour:
- Reset (reset=0, asynchronous) sets the FSM to IDLE and clears key_ready, busy, done, pt_out, the round counter, the state register and the whitening-key register. Round-key store contents are don't-care after reset.
- FSM states: IDLE, KEXP, DEC.
  - IDLE, key_load=1 -> KEXP. Latches key_in, clears key_ready, resets the counter to 0.
  - IDLE, start=1 and key_ready=1 -> DEC. Latches the whitened ct_in.
  - key_load and start asserted together in IDLE: key_load wins and start is dropped.
  - start with key_ready=0 is ignored.
  - Any strobe while busy=1 is ignored.
- KEXP (31 cycles):
  - Each cycle i=0..30 writes {rk_2i, rk_2i+1} to store address i.
  - Standard Piccolo-128 schedule: rk_j = k_((j+2) mod 8) XOR con_j. Before use, when (j+2) mod 8 == 0, the words are permuted (k0..k7) <- (k2,k1,k6,k7,k0,k3,k4,k5).
  - con_2i|con_2i+1 = ({c_i+1, c0, c_i+1, 2'b00, c_i+1, c0, c_i+1}) XOR 32'h6547a98b, where c_x is the 5-bit value x.
  - Also latches wk0=k0L|k1R, wk1=k1L|k0R, wk2=k4L|k7R, wk3=k7L|k4R (L/R = high/low byte).
  - After cycle 30: key_ready=1, return to IDLE.
- DEC entry:
  - State X0..X3 = ct_in with X0 ^= wk2 and X2 ^= wk3.
- DEC (31 cycles, round r=0..30):
  - Read store address 30-r as {a,b}.
  - Round key pair is (a,b) if r is even, (b,a) if r is odd. These are Piccolo decryption keys rk'_2r, rk'_2r+1.
  - X1 ^= F(X0) ^ rk'_2r.
  - X3 ^= F(X2) ^ rk'_2r+1.
  - F = S-layer, diffusion matrix M over GF(2^4) with x^4+x+1, S-layer. Identical to the encryption core.
  - Rounds 0..29 apply the round permutation RP: byte order (0..7) -> (2,7,4,1,6,3,0,5). Round 30 omits RP.
- Exit:
  - pt_out = X with X0 ^= wk0 and X2 ^= wk1.
  - done=1 in the cycle after round 30, i.e. 32 cycles after the start edge. FSM returns to IDLE.
  - busy falls in the same cycle as done.
- Back-to-back blocks: start may be asserted in the cycle done is high; it is accepted, since the FSM is already IDLE that cycle.
- Reset mid-KEXP or mid-DEC: the operation is aborted; key_ready=0 and a fresh key_load is required.

Optional Feature:
- Macro: PICCOLO128_DEC_ENCMODE_EN.
- When defined:
  - Adds input `mode` (1 bit), sampled with start. 1 = encrypt.
  - Encrypt path: reads address r with no swap, uses wk0/wk1 on entry and wk2/wk3 on exit, same 32-cycle latency.
- When undefined:
  - No `mode` port; decrypt only.
  - Encrypt-only logic is absent.

Test Plan:
- Key expansion: reset, key_load with K=00112233445566778899aabbccddeeff -> busy=1 for 31 cycles, then key_ready=1. Store address 0 = rk0|rk1 per the golden model.
- Known answer: after the key above, start with ct_in = encryption core output for PT 0123456789abcdef -> done 32 cycles later, pt_out=0123456789abcdef. Also check all-zero key/PT and all-ones key/PT.
- Ignored strobes:
  - start before any key_load -> no busy, no done.
  - start and key_load mid-DEC -> result unchanged and latency still 32.
- Back-to-back: start re-asserted in the done cycle with a second ciphertext -> second done exactly 32 cycles later, correct plaintext.
- Asynchronous reset: drop reset mid-DEC (round 15) -> all outputs 0 immediately. A start after release is ignored until key_load completes.
- Round trip with ENCMODE_EN: random keys and blocks, encrypt then decrypt through the core (1000 iterations) -> plaintext recovered each time.
